// File: rtl/display_pkg.sv
// Shared display types and screen geometry, used by the plot buffer and by the
// map and character display controllers.
package display_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef logic [2:0] color_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    color_t     color;
  } plot_t;

endpackage

// File: rtl/plot_fifo_mem.sv
// Register-array storage for the plot buffer: one synchronous write port and
// one asynchronous read port. Contents are not reset.
module plot_fifo_mem
  import display_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock_50,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  plot_t         wdata,
  input  logic [AW-1:0] raddr,
  output plot_t         rdata
);

  plot_t mem [DEPTH];

  // Write the addressed entry on the clock edge
  always_ff @(posedge clock_50) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vga_plot_buffer.sv
// Elastic plot buffer between the display plot mux and the VGA adapter
// framebuffer write port. Off-screen requests are clipped and counted,
// overflow requests are dropped and counted, accepted pixels drain in order
// under a valid/ready handshake with show-ahead outputs.
// Optional build macro: PLOT_COALESCE_EN (merge a repeated (x,y) push into
// the most recently queued entry instead of allocating a new one).
module vga_plot_buffer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SCREEN_W = display_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = display_pkg::SCREEN_H,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clock_50,
  input  logic                     resetn,
  input  logic                     in_plot,
  input  logic [7:0]               in_x,
  input  logic [7:0]               in_y,
  input  logic [2:0]               in_color,
  output logic                     in_ready,
  output logic                     fb_plot,
  output logic [7:0]               fb_x,
  output logic [7:0]               fb_y,
  output logic [2:0]               fb_color,
  input  logic                     fb_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         clip_cnt
);

  import display_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] waddr;
  plot_t         wdata;
  plot_t         head;
  plot_t         last_pop;
  logic          in_range;
  logic          push_req;
  logic          full;
  logic          pop;
  logic          alloc;
  logic          drop;
  logic          clip;
  logic          coalesce;

  assign in_range = ({24'd0, in_x} < SCREEN_W) && ({24'd0, in_y} < SCREEN_H);
  assign push_req = in_plot && in_range;
  assign clip     = in_plot && !in_range;
  assign full     = (level == LW'(DEPTH));
  assign fb_plot  = (level != '0);
  assign in_ready = !full;
  assign pop      = fb_plot && fb_ready;
  assign wdata    = '{x: in_x, y: in_y, color: in_color};

`ifdef PLOT_COALESCE_EN
  logic [7:0] tail_x;
  logic [7:0] tail_y;

  // While anything is queued, the most recently written entry is the tail.
  // It cannot be merged into if it is also the head leaving this cycle.
  assign coalesce = push_req && fb_plot &&
                    (tail_x == in_x) && (tail_y == in_y) &&
                    !((level == LW'(1)) && pop);
  assign waddr    = coalesce ? (wr_ptr - AW'(1)) : wr_ptr;

  // Remember the coordinates of the most recently allocated entry
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      tail_x <= '0;
      tail_y <= '0;
    end else if (alloc) begin
      tail_x <= in_x;
      tail_y <= in_y;
    end
  end
`else
  assign coalesce = 1'b0;
  assign waddr    = wr_ptr;
`endif

  // A full buffer drops even when the head leaves this same cycle
  assign alloc = push_req && !coalesce && !full;
  assign drop  = push_req && !coalesce && full;

  plot_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock_50 (clock_50),
    .we       (alloc || coalesce),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (rd_ptr),
    .rdata    (head)
  );

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(alloc) - LW'(pop);
    end
  end

  // Hold the last popped pixel so the outputs stay stable while empty
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      last_pop <= '0;
    end else if (pop) begin
      last_pop <= head;
    end
  end

  // Saturating clip and drop counters
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
      clip_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (clip && (clip_cnt != '1)) clip_cnt <= clip_cnt + CNT_W'(1);
    end
  end

  // Show-ahead head outputs
  always_comb begin
    fb_x     = last_pop.x;
    fb_y     = last_pop.y;
    fb_color = last_pop.color;
    if (fb_plot) begin
      fb_x     = head.x;
      fb_y     = head.y;
      fb_color = head.color;
    end
  end

endmodule
